// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unknown funct3 encodings fall back to a full-word access.
    function automatic logic [3:0] be_of(input logic [2:0] fun_3, input logic [1:0] addr_lo);
        case (fun_3)
            F3_B, F3_BU: be_of = 4'b0001 << addr_lo;
            F3_H, F3_HU: be_of = 4'b0011 << {addr_lo[1], 1'b0};
            default:     be_of = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for one access: byte enables, replicated store data, aligned low address.
// MEM_MISALIGN_TRAP_EN adds the misalign detect output.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  fun_3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    output logic [1:0]  addr_lo_al,
    output logic [3:0]  be,
    output logic [31:0] wdata
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    logic misalign_raw;

    always_comb begin
        addr_lo_al   = 2'b00;
        wdata        = st_data;
        misalign_raw = 1'b0;
        case (fun_3)
            F3_B, F3_BU: begin
                addr_lo_al = addr_lo;
                wdata      = {4{st_data[7:0]}};
            end
            F3_H, F3_HU: begin
                addr_lo_al   = {addr_lo[1], 1'b0};
                wdata        = {2{st_data[15:0]}};
                misalign_raw = addr_lo[0];
            end
            default: begin
                misalign_raw = |addr_lo;
            end
        endcase
        be = be_of(fun_3, addr_lo_al);
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = misalign_raw;
`else
    // Without the trap, misaligned accesses are silently forced onto aligned lanes.
    logic unused_misalign;
    assign unused_misalign = misalign_raw;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a req/ack single-ported data memory.
// MEM_MISALIGN_TRAP_EN turns misaligned h/w accesses into a misalign_o trap.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [2:0]        fun_3,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       st_data_i,
    output logic              stall_o,
    output logic [31:0]       ld_data_o,
    output logic              ld_valid_o,
    output logic              bus_err_o,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [3:0]        dm_be_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [31:0]       dm_wdata_o,
    input  logic              dm_ack_i,
    input  logic [31:0]       dm_rdata_i
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         addr_lo_q;
    logic               err_q;
    logic [1:0]         addr_lo_al;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic               timeout;

    assign timeout = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign;
    logic mis_q;
`endif

    mem_lane_align u_lane_align (
        .fun_3      (fun_3),
        .addr_lo    (addr_i[1:0]),
        .st_data    (st_data_i),
        .addr_lo_al (addr_lo_al),
        .be         (be),
        .wdata      (wdata)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign   (misalign)
`endif
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        stall_o    = 1'b0;
        dm_req_o   = 1'b0;
        ld_valid_o = 1'b0;
        bus_err_o  = 1'b0;
        case (state)
            IDLE: begin
                stall_o = mem_req_i;
                if (mem_req_i) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    state_nxt = misalign ? DONE : REQ;
`else
                    state_nxt = REQ;
`endif
                end
            end
            REQ: begin
                stall_o  = 1'b1;
                dm_req_o = 1'b1;
                if (dm_ack_i || timeout) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                bus_err_o = err_q;
`ifdef MEM_MISALIGN_TRAP_EN
                ld_valid_o = !dm_we_o && !err_q && !mis_q;
`else
                ld_valid_o = !dm_we_o && !err_q;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o = (state == DONE) && mis_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt_q      <= '0;
            addr_lo_q  <= 2'b00;
            err_q      <= 1'b0;
            ld_data_o  <= '0;
            dm_we_o    <= 1'b0;
            dm_be_o    <= '0;
            dm_addr_o  <= '0;
            dm_wdata_o <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (mem_req_i) begin
                        dm_we_o    <= mem_we_i;
                        dm_be_o    <= be;
                        dm_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                        dm_wdata_o <= wdata;
                        addr_lo_q  <= addr_lo_al;
                        err_q      <= 1'b0;
                        cnt_q      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
                        mis_q      <= misalign;
`endif
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Ack beats a simultaneous timeout.
                    if (dm_ack_i) begin
                        if (!dm_we_o) ld_data_o <= dm_rdata_i >> {addr_lo_q, 3'b000};
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (ACK_TIMEOUT overridden to 8).
// Honours MEM_MISALIGN_TRAP_EN to match the DUT build.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [2:0]  fun_3;
    logic [31:0] addr_i;
    logic [31:0] st_data_i;
    logic        stall_o;
    logic [31:0] ld_data_o;
    logic        ld_valid_o;
    logic        bus_err_o;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_wdata_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_ctrl #(.ACK_TIMEOUT(8), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req_i  (mem_req_i),
        .mem_we_i   (mem_we_i),
        .fun_3      (fun_3),
        .addr_i     (addr_i),
        .st_data_i  (st_data_i),
        .stall_o    (stall_o),
        .ld_data_o  (ld_data_o),
        .ld_valid_o (ld_valid_o),
        .bus_err_o  (bus_err_o),
        .dm_req_o   (dm_req_o),
        .dm_we_o    (dm_we_o),
        .dm_be_o    (dm_be_o),
        .dm_addr_o  (dm_addr_o),
        .dm_wdata_o (dm_wdata_o),
        .dm_ack_i   (dm_ack_i),
        .dm_rdata_i (dm_rdata_i)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_o (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        mem_req_i = 1'b1;
        mem_we_i  = we;
        fun_3     = f3;
        addr_i    = a;
        st_data_i = d;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; fun_3 = F3_W;
        addr_i = '0; st_data_i = '0; dm_ack_i = 1'b0; dm_rdata_i = '0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_stall", stall_o, 0);
        check("rst_dm_req", dm_req_o, 0);
        check("rst_ld_valid", ld_valid_o, 0);
        check("rst_bus_err", bus_err_o, 0);
        check("rst_ld_data", ld_data_o, 0);
        check("rst_be", dm_be_o, 0);
        check("rst_addr", dm_addr_o, 0);
        check("rst_wdata", dm_wdata_o, 0);
        check("rst_we", dm_we_o, 0);

        // sw 0x104, ack on first REQ cycle
        issue(1'b1, F3_W, 32'h104, 32'hDEADBEEF);
        settle();
        check("sw_idle_stall", stall_o, 1);
        check("sw_idle_req", dm_req_o, 0);
        tick();
        dm_ack_i = 1'b1;
        settle();
        check("sw_req", dm_req_o, 1);
        check("sw_stall", stall_o, 1);
        check("sw_we", dm_we_o, 1);
        check("sw_be", dm_be_o, 4'b1111);
        check("sw_addr", dm_addr_o, 32'h104);
        check("sw_wdata", dm_wdata_o, 32'hDEADBEEF);
        tick();
        dm_ack_i = 1'b0; mem_req_i = 1'b0;
        settle();
        check("sw_done_stall", stall_o, 0);
        check("sw_done_req", dm_req_o, 0);
        check("sw_done_valid", ld_valid_o, 0);
        check("sw_done_err", bus_err_o, 0);
        tick();

        // lb 0x203, 4 wait cycles then ack
        issue(1'b0, F3_B, 32'h203, 32'h0);
        settle();
        check("lb_idle_stall", stall_o, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("lb_wait%0d_stall", i), stall_o, 1);
            check($sformatf("lb_wait%0d_req", i), dm_req_o, 1);
            tick();
        end
        dm_ack_i = 1'b1; dm_rdata_i = 32'h80112233;
        settle();
        check("lb_be", dm_be_o, 4'b1000);
        check("lb_addr", dm_addr_o, 32'h200);
        check("lb_we", dm_we_o, 0);
        check("lb_ack_stall", stall_o, 1);
        tick();
        dm_ack_i = 1'b0; mem_req_i = 1'b0; dm_rdata_i = 32'hFFFFFFFF;
        settle();
        check("lb_valid", ld_valid_o, 1);
        check("lb_data", ld_data_o, 32'h00000080);
        check("lb_done_stall", stall_o, 0);
        check("lb_done_err", bus_err_o, 0);
        tick();
        settle();
        check("lb_valid_pulse", ld_valid_o, 0);
        check("lb_data_hold", ld_data_o, 32'h00000080);

        // sh 0x12
        issue(1'b1, F3_H, 32'h12, 32'h0000ABCD);
        tick();
        dm_ack_i = 1'b1;
        settle();
        check("sh_be", dm_be_o, 4'b1100);
        check("sh_wdata", dm_wdata_o, 32'hABCDABCD);
        check("sh_addr", dm_addr_o, 32'h10);
        tick();
        dm_ack_i = 1'b0; mem_req_i = 1'b0;
        settle();
        check("sh_valid", ld_valid_o, 0);
        check("sh_ld_data_keep", ld_data_o, 32'h00000080);
        tick();

        // lw 0x300 with no ack: timeout after 8 REQ cycles
        issue(1'b0, F3_W, 32'h300, 32'h0);
        tick();
        mem_req_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            check($sformatf("to_req%0d", i), dm_req_o, 1);
            check($sformatf("to_err_early%0d", i), bus_err_o, 0);
            tick();
        end
        settle();
        check("to_bus_err", bus_err_o, 1);
        check("to_valid", ld_valid_o, 0);
        check("to_done_req", dm_req_o, 0);
        check("to_done_stall", stall_o, 0);
        tick();
        settle();
        check("to_err_pulse", bus_err_o, 0);
        check("to_idle_req", dm_req_o, 0);
        check("to_idle_stall", stall_o, 0);

        // lb 0x301: ack lands in the timeout cycle, ack wins
        issue(1'b0, F3_B, 32'h301, 32'h0);
        tick();
        mem_req_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        dm_ack_i = 1'b1; dm_rdata_i = 32'h0000A500;
        settle();
        check("race_req", dm_req_o, 1);
        check("race_be", dm_be_o, 4'b0010);
        tick();
        dm_ack_i = 1'b0;
        settle();
        check("race_valid", ld_valid_o, 1);
        check("race_err", bus_err_o, 0);
        check("race_data", ld_data_o, 32'h000000A5);
        tick();

        // reset during the second REQ cycle, then a late ack
        issue(1'b0, F3_W, 32'h400, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        settle();
        check("rst_req2_req", dm_req_o, 1);
        tick();
        rst = 1'b0; mem_req_i = 1'b0; dm_ack_i = 1'b1; dm_rdata_i = 32'h12345678;
        settle();
        check("rstq_req", dm_req_o, 0);
        check("rstq_stall", stall_o, 0);
        check("rstq_ld_data", ld_data_o, 0);
        check("rstq_be", dm_be_o, 0);
        mem_req_i = 1'b1;
        settle();
        check("rstq_stall_follow", stall_o, 1);
        mem_req_i = 1'b0;
        settle();
        tick();
        settle();
        check("rstq_valid", ld_valid_o, 0);
        check("rstq_err", bus_err_o, 0);
        check("rstq_req2", dm_req_o, 0);
        dm_ack_i = 1'b0;
        tick();

        // lw 0x102 misaligned
        issue(1'b0, F3_W, 32'h102, 32'h0);
        tick();
        mem_req_i = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        settle();
        check("mis_trap", misalign_o, 1);
        check("mis_req", dm_req_o, 0);
        check("mis_valid", ld_valid_o, 0);
        check("mis_err", bus_err_o, 0);
        check("mis_stall", stall_o, 0);
        tick();
        settle();
        check("mis_pulse", misalign_o, 0);
        check("mis_idle_req", dm_req_o, 0);
`else
        dm_ack_i = 1'b1; dm_rdata_i = 32'h11223344;
        settle();
        check("mis_req", dm_req_o, 1);
        check("mis_addr", dm_addr_o, 32'h100);
        check("mis_be", dm_be_o, 4'b1111);
        tick();
        dm_ack_i = 1'b0;
        settle();
        check("mis_valid", ld_valid_o, 1);
        check("mis_data", ld_data_o, 32'h11223344);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences MEM-stage loads and stores onto a single-ported data memory that uses a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Generates byte enables and replicated store data from fun_3 and the address.
- Returns lane-aligned raw load data, which the existing load sign/zero-extension filter consumes.

Parameters:
- ACK_TIMEOUT, 255: maximum REQ cycles to wait for dm_ack before aborting with bus_err_o.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock (rising edge).
- rst  in  1  synchronous, active-high reset.
- mem_req_i  in  1  MEM-stage instruction is a load or store.
- mem_we_i  in  1  1 = store, 0 = load.
- fun_3  in  3  RV32I funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
- addr_i  in  ADDR_W  effective byte address.
- st_data_i  in  32  store data, value in the low bits.
- stall_o  out  1  freeze IF..MEM.
- ld_data_o  out  32  read word shifted right by 8*addr[1:0].
- ld_valid_o  out  1  one-cycle pulse; ld_data_o valid.
- bus_err_o  out  1  one-cycle pulse on timeout.
- dm_req_o  out  1  memory request.
- dm_we_o  out  1  memory write.
- dm_be_o  out  4  byte enables.
- dm_addr_o  out  ADDR_W  word-aligned address (low 2 bits zero).
- dm_wdata_o  out  32  lane-replicated store data.
- dm_ack_i  in  1  memory accepted the write or returned read data.
- dm_rdata_i  in  32  read word, valid with dm_ack_i.

Behaviour:
- States: IDLE, REQ, DONE.
- Reset: state=IDLE. ld_data_o=0, ld_valid_o=0, bus_err_o=0, dm_req_o=0, dm_we_o=0, dm_be_o=0, dm_addr_o=0, dm_wdata_o=0, timeout counter=0.
- IDLE:
  - When mem_req_i=1, register we, be, word address, wdata and addr[1:0]; go to REQ.
  - stall_o = mem_req_i (combinational, same cycle).
- REQ:
  - dm_req_o=1 with registered fields held stable; stall_o=1; counter increments.
  - If dm_ack_i=1: capture ld_data_o = dm_rdata_i >> (8*addr_lo) for loads; for stores ld_data_o keeps its value. Go to DONE.
  - Ack is accepted in the first REQ cycle, so minimum access is 3 cycles: IDLE, REQ, DONE.
  - If counter reaches ACK_TIMEOUT-1 without ack: go to DONE with the error flag set.
  - If dm_ack_i and the timeout occur in the same cycle, ack wins.
- DONE:
  - stall_o=0 so the pipeline advances.
  - dm_req_o=0.
  - ld_valid_o=1 if the access was a load without error; bus_err_o=1 if error.
  - Next state is IDLE unconditionally; the next instruction's mem_req_i is sampled there.
- Byte enables:
  - b/bu: 4'b0001 << addr[1:0].
  - h/hu: 4'b0011 << (2*addr[1]).
  - w: 4'b1111.
  - Other funct3: 4'b1111 treated as word.
- Store data:
  - b: {4{st_data_i[7:0]}}.
  - h: {2{st_data_i[15:0]}}.
  - w: st_data_i.
- Misaligned access (optional feature off): h with addr[0]=1 clears addr[0]; w clears addr[1:0]. The access proceeds on the aligned lanes.
- dm_ack_i while in IDLE or DONE: ignored.
- rst asserted in any state: next edge returns to IDLE with dm_req_o=0. A pending ack is dropped and no ld_valid_o or bus_err_o pulse is generated.
- mem_req_i is assumed stable while stall_o=1. Changes during REQ have no effect because fields are registered.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_o (1 bit, reset 0).
  - A misaligned h/hu or w access in IDLE goes directly to DONE with no dm_req_o.
  - In that DONE cycle misalign_o=1, ld_valid_o=0 and bus_err_o=0.
- Undefined: port absent; forced-alignment behaviour above applies.

Decomposition:
- Package mem_ctrl_pkg:
  - State enum (IDLE/REQ/DONE).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Function be_of(fun_3, addr_lo).
- Sub-module mem_lane_align: combinational block for byte-enable generation, store-data replication and misalign detect. The FSM, counter and capture registers stay in mem_access_ctrl.

Test Plan:
- sw addr 0x104, data 0xDEADBEEF, ack on 1st REQ cycle -> dm_be_o=1111, dm_addr_o=0x104, dm_wdata_o=0xDEADBEEF; stall_o high 2 cycles then low in DONE; ld_valid_o=0.
- lb addr 0x203, dm_rdata_i=0x80112233, ack after 4 wait cycles -> dm_be_o=1000, dm_addr_o=0x200, ld_data_o=0x00000080 with ld_valid_o pulse; stall_o high 6 cycles.
- sh addr 0x12, st_data_i=0x0000ABCD -> dm_be_o=1100, dm_wdata_o=0xABCDABCD.
- Load, no ack, ACK_TIMEOUT=8 -> bus_err_o pulses after 8 REQ cycles; ld_valid_o=0; FSM back in IDLE.
- rst asserted on 2nd REQ cycle, then ack arrives -> dm_req_o=0 next cycle; no ld_valid_o pulse; stall_o=mem_req_i afterwards.
- lw addr 0x102: with MEM_MISALIGN_TRAP_EN -> misalign_o pulse, dm_req_o never asserted. Without it -> dm_addr_o=0x100, be=1111.
